// File: rtl/alu_result_checker_if.sv
// alu_result_checker_if: ALU stimulus/response tuple carried over a valid/ready handshake.
interface alu_result_checker_if #(
  parameter int unsigned n = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [n-1:0] a;
  logic [n-1:0] b;
  logic [2:0]   sel;
  logic [n-1:0] s;
  logic         co;

  // Producer side: the ALU / stimulus source
  modport master (
    output in_valid, a, b, sel, s, co,
    input  in_ready
  );

  // Consumer side: the checker
  modport slave (
    input  in_valid, a, b, sel, s, co,
    output in_ready
  );
endinterface

// File: rtl/alu_result_checker.sv
// alu_result_checker: consuming end of the ALU stimulus/response link.
// Recomputes the expected {co,s} in a 2-stage pipeline, counts passes and
// fails and latches the first mismatching vector.
// Optional macro STOP_ON_FAIL_EN: stop accepting vectors after the first
// mismatch and finish the run once the pipeline drains.
module alu_result_checker #(
  parameter int unsigned n     = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CNT_W-1:0]    vec_total,
  alu_result_checker_if.slave bus,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [CNT_W-1:0]    pass_cnt,
  output logic [CNT_W-1:0]    fail_cnt,
  output logic [2:0]          fail_sel,
  output logic [n-1:0]        fail_a,
  output logic [n-1:0]        fail_b,
  output logic [n-1:0]        fail_s
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] total_q, total_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic             stop_q, stop_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_d, done_d, pass_d;
  logic [CNT_W-1:0] pass_cnt_d, fail_cnt_d;
  logic [2:0]       fail_sel_d;
  logic [n-1:0]     fail_a_d, fail_b_d, fail_s_d;

  // Stage 1: accepted tuple
  logic             s1_valid;
  logic [n-1:0]     s1_a, s1_b, s1_s;
  logic [2:0]       s1_sel;
  logic             s1_co;
  // Stage 2: compare result plus the vector needed for first-fail capture
  logic             s2_valid, s2_fail;
  logic [2:0]       s2_sel;
  logic [n-1:0]     s2_a, s2_b, s2_s;

  logic [n:0]       exp_c;
  logic             mis_c;
  logic             arm_c;
  logic             xfer_c;

  assign arm_c        = start && (state_q != RUN);
  assign xfer_c       = bus.in_valid && in_ready_q;
  assign bus.in_ready = in_ready_q;

  // Reference ALU on the stage-1 tuple, evaluated at n+1 bits
  always_comb begin
    exp_c = '0;
    case (s1_sel)
      3'd0: exp_c = {1'b0, s1_a} + {1'b0, s1_b};
      3'd1: exp_c = {1'b0, s1_a} - {1'b0, s1_b};
      3'd2: exp_c = {1'b0, s1_a & s1_b};
      3'd3: exp_c = {1'b0, s1_a | s1_b};
      3'd4: exp_c = {1'b0, s1_a ^ s1_b};
      3'd5: exp_c = {1'b0, ~s1_a};
      3'd6: exp_c = {s1_a, 1'b0};
      3'd7: exp_c = {1'b0, s1_b};
      default: exp_c = '0;
    endcase
  end

  assign mis_c = s1_valid && ({s1_co, s1_s} != exp_c);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; DONE is entered on the edge that retires the last vector
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = (vec_total == '0) ? DONE : RUN;
      RUN:        if (((acc_q == total_q) || stop_q) && !s1_valid) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // Next values of run control, counters and registered outputs
  always_comb begin
    acc_d      = acc_q;
    total_d    = total_q;
    stop_d     = stop_q;
    pass_cnt_d = pass_cnt;
    fail_cnt_d = fail_cnt;
    fail_sel_d = fail_sel;
    fail_a_d   = fail_a;
    fail_b_d   = fail_b;
    fail_s_d   = fail_s;
    if (arm_c) begin
      acc_d      = '0;
      total_d    = vec_total;
      stop_d     = 1'b0;
      pass_cnt_d = '0;
      fail_cnt_d = '0;
      fail_sel_d = '0;
      fail_a_d   = '0;
      fail_b_d   = '0;
      fail_s_d   = '0;
    end else begin
      if (xfer_c) acc_d = acc_q + CNT_W'(1);
`ifdef STOP_ON_FAIL_EN
      // in_ready falls in the cycle the mismatch sits in stage 2
      if (mis_c) stop_d = 1'b1;
`endif
      if (s2_valid) begin
        if (s2_fail) begin
          fail_cnt_d = fail_cnt + CNT_W'(1);
          if (fail_cnt == '0) begin
            fail_sel_d = s2_sel;
            fail_a_d   = s2_a;
            fail_b_d   = s2_b;
            fail_s_d   = s2_s;
          end
        end else begin
          pass_cnt_d = pass_cnt + CNT_W'(1);
        end
      end
    end
    in_ready_d = (state_d == RUN) && (acc_d < total_d) && !stop_d;
    busy_d     = (state_d == RUN);
    done_d     = (state_d == DONE);
    pass_d     = done_d && (fail_cnt_d == '0);
  end

  // Run control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      total_q    <= '0;
      stop_q     <= 1'b0;
      in_ready_q <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      fail_sel   <= '0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_s     <= '0;
    end else begin
      acc_q      <= acc_d;
      total_q    <= total_d;
      stop_q     <= stop_d;
      in_ready_q <= in_ready_d;
      busy       <= busy_d;
      done       <= done_d;
      pass       <= pass_d;
      pass_cnt   <= pass_cnt_d;
      fail_cnt   <= fail_cnt_d;
      fail_sel   <= fail_sel_d;
      fail_a     <= fail_a_d;
      fail_b     <= fail_b_d;
      fail_s     <= fail_s_d;
    end
  end

  // Two-stage check pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_s     <= '0;
      s1_sel   <= '0;
      s1_co    <= 1'b0;
      s2_valid <= 1'b0;
      s2_fail  <= 1'b0;
      s2_sel   <= '0;
      s2_a     <= '0;
      s2_b     <= '0;
      s2_s     <= '0;
    end else begin
      s1_valid <= xfer_c;
      if (xfer_c) begin
        s1_a   <= bus.a;
        s1_b   <= bus.b;
        s1_s   <= bus.s;
        s1_sel <= bus.sel;
        s1_co  <= bus.co;
      end
      s2_valid <= s1_valid;
      s2_fail  <= mis_c;
      if (s1_valid) begin
        s2_sel <= s1_sel;
        s2_a   <= s1_a;
        s2_b   <= s1_b;
        s2_s   <= s1_s;
      end
    end
  end

endmodule

// File: tb/tb_alu_result_checker.sv
// tb_alu_result_checker: randomized scoreboard bench for alu_result_checker.
`timescale 1ns/1ps
module tb_alu_result_checker;
  localparam int unsigned N  = 4;
  localparam int unsigned CW = 8;
  localparam int          M  = 16;  // 2**N

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] vec_total = '0;
  logic          busy, done, pass;
  logic [CW-1:0] pass_cnt, fail_cnt;
  logic [2:0]    fail_sel;
  logic [N-1:0]  fail_a, fail_b, fail_s;

  alu_result_checker_if #(.n(N)) bus ();

  alu_result_checker #(.n(N), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .vec_total(vec_total), .bus(bus),
    .busy(busy), .done(done), .pass(pass), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .fail_sel(fail_sel), .fail_a(fail_a), .fail_b(fail_b), .fail_s(fail_s)
  );

  always #5 clk = ~clk;

  typedef struct { int a; int b; int sel; int s; int co; } vec_t;
  typedef struct { int stamp; bit ok; int fsel; int fa; int fb; int fs; } sb_t;

  vec_t stim_q[$];
  sb_t  sb_q[$];
  int   cyc = 0;
  int   tests = 0, fails = 0;
  int   exp_pass, exp_fail;
  bit   have_f;
  vec_t first_f;
  int   prev_p = 0, prev_f = 0;
  int   bad_pct;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Behavioural ALU: plain integer arithmetic modulo 2**N
  function automatic void ref_alu(input int a, input int b, input int sel,
                                  output int s, output int co);
    co = 0;
    case (sel)
      0: begin s = (a + b) % M; co = (a + b) / M; end
      1: begin s = (a - b + M) % M; co = (a < b) ? 1 : 0; end
      2: s = a & b;
      3: s = a | b;
      4: s = a ^ b;
      5: s = M - 1 - a;
      6: begin s = (2 * a) % M; co = a / (M / 2); end
      default: s = b;
    endcase
  endfunction

  // bad: 0 correct, 1 wrong carry, 2 wrong sum
  function automatic vec_t mk_vec(input int a, input int b, input int sel, input int bad);
    vec_t v;
    v.a = a; v.b = b; v.sel = sel;
    ref_alu(a, b, sel, v.s, v.co);
    if (bad == 1) v.co = 1 - v.co;
    if (bad == 2) v.s = (v.s + 1) % M;
    return v;
  endfunction

  function automatic vec_t rand_vec(input int pct);
    int bad;
    bad = (int'($urandom_range(99)) < pct) ? int'($urandom_range(2, 1)) : 0;
    return mk_vec(int'($urandom_range(M - 1)), int'($urandom_range(M - 1)),
                  int'($urandom_range(7)), bad);
  endfunction

  // A transfer was issued: push the expected outcome
  function automatic void on_xfer(input vec_t v);
    sb_t e;
    int es, eco;
    ref_alu(v.a, v.b, v.sel, es, eco);
    e.ok = (es == v.s) && (eco == v.co);
    if (e.ok) exp_pass++;
    else begin
      exp_fail++;
      if (!have_f) begin have_f = 1'b1; first_f = v; end
    end
    e.stamp = cyc + 1;
    e.fsel = first_f.sel; e.fa = first_f.a; e.fb = first_f.b; e.fs = first_f.s;
    sb_q.push_back(e);
  endfunction

  // Monitor: every counter step must match the oldest outstanding vector
  always begin : monitor
    sb_t e;
    @(posedge clk);
    #1;
    if (int'(pass_cnt) != prev_p || int'(fail_cnt) != prev_f) begin
      if (int'(pass_cnt) >= prev_p && int'(fail_cnt) >= prev_f) begin
        if (sb_q.size() == 0) begin
          check("sb_update_without_vector", int'(pass_cnt) + int'(fail_cnt), prev_p + prev_f);
        end else begin
          e = sb_q.pop_front();
          check("sb_latency", cyc, e.stamp + 2);
          check("sb_pass_step", int'(pass_cnt) - prev_p, e.ok ? 1 : 0);
          check("sb_fail_step", int'(fail_cnt) - prev_f, e.ok ? 0 : 1);
          if (!e.ok)
            check("sb_fail_vector", {fail_sel, fail_a, fail_b, fail_s},
                  {3'(e.fsel), N'(e.fa), N'(e.fb), N'(e.fs)});
        end
      end
      prev_p = int'(pass_cnt);
      prev_f = int'(fail_cnt);
    end
  end

  // Called at a negedge; returns at the following negedge with start low
  task automatic arm(input int total);
    exp_pass = 0; exp_fail = 0; have_f = 1'b0;
    first_f = '{0, 0, 0, 0, 0};
    start = 1'b1;
    vec_total = CW'(total);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drive(input int max_xfer, input int gap_pct, input bit mid_start,
                       output int ready_cycles, output int last_stamp);
    int idx = 0, guard = 0;
    bit pulsed = 1'b0;
    ready_cycles = 0; last_stamp = 0;
    while (idx < max_xfer && guard < 4000) begin
      start = 1'b0;
      if (mid_start && !pulsed && idx >= max_xfer / 2) begin
        start = 1'b1; vec_total = CW'(3); pulsed = 1'b1;
      end
      if (bus.in_ready) ready_cycles++;
      if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) bus.in_valid = 1'b0;
      else begin
        bus.in_valid = 1'b1;
        bus.a = N'(stim_q[idx].a); bus.b = N'(stim_q[idx].b);
        bus.sel = 3'(stim_q[idx].sel); bus.s = N'(stim_q[idx].s);
        bus.co = stim_q[idx].co[0];
      end
      if (bus.in_valid && bus.in_ready) begin
        on_xfer(stim_q[idx]);
        last_stamp = cyc + 1;
        idx++;
      end
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
    check("drive_complete", idx, max_xfer);
  endtask

  task automatic wait_done(inout int rc, output int done_cyc);
    int guard = 0;
    bus.in_valid = 1'b0;
    while (!done && guard < 50) begin
      if (bus.in_ready) rc++;
      @(negedge clk);
      guard++;
    end
    done_cyc = cyc;
    check("done_reached", done, 1);
  endtask

  task automatic final_checks();
    check("pass_cnt", pass_cnt, exp_pass);
    check("fail_cnt", fail_cnt, exp_fail);
    check("pass_flag", pass, (exp_fail == 0) ? 1 : 0);
    check("busy_in_done", busy, 0);
    check("sb_drained", sb_q.size(), 0);
    if (have_f)
      check("fail_regs", {fail_sel, fail_a, fail_b, fail_s},
            {3'(first_f.sel), N'(first_f.a), N'(first_f.b), N'(first_f.s)});
    else
      check("fail_regs_clear", {fail_sel, fail_a, fail_b, fail_s}, 0);
  endtask

  task automatic run_test(input int gap_pct, input bit chk_ready, input bit mid_start);
    int rc, last, dc;
    arm(stim_q.size());
    drive(stim_q.size(), gap_pct, mid_start, rc, last);
    wait_done(rc, dc);
    check("done_latency", dc, last + 2);
    if (chk_ready) check("ready_cycles", rc, stim_q.size());
    final_checks();
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int rc, last;
`ifdef STOP_ON_FAIL_EN
    bad_pct = 0;
`else
    bad_pct = 20;
`endif
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sel = '0; bus.s = '0; bus.co = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle after reset, no start
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_outputs", {bus.in_ready, busy, done, pass, pass_cnt, fail_cnt}, 0);
    end

    // All opcodes, a=b=0..9, correct ALU, continuous valid
    stim_q.delete();
    for (int sel = 0; sel < 8; sel++)
      for (int v = 0; v < 10; v++) stim_q.push_back(mk_vec(v, v, sel, 0));
    run_test(0, 1'b1, 1'b0);

    // ADD 9+9 with correct carry
    stim_q.delete();
    stim_q.push_back('{9, 9, 0, 2, 1});
    run_test(0, 1'b1, 1'b0);
    check("add99_pass_cnt", pass_cnt, 1);

`ifndef STOP_ON_FAIL_EN
    // Same vector with carry dropped
    stim_q.delete();
    stim_q.push_back('{9, 9, 0, 2, 0});
    run_test(0, 1'b1, 1'b0);
    check("add99_fail_cnt", fail_cnt, 1);
    check("add99_fail_sel", fail_sel, 0);
    check("add99_fail_a", fail_a, 9);
    check("add99_fail_s", fail_s, 2);

    // Errors on vectors 2 (SUB wrong borrow) and 4 (SHL wrong sum)
    stim_q.delete();
    stim_q.push_back(mk_vec(1, 2, 0, 0));
    stim_q.push_back('{3, 5, 1, 14, 0});
    stim_q.push_back(mk_vec(6, 3, 2, 0));
    stim_q.push_back(mk_vec(5, 0, 6, 2));
    stim_q.push_back(mk_vec(7, 12, 4, 0));
    run_test(0, 1'b1, 1'b0);
    check("two_err_fail_cnt", fail_cnt, 2);
    check("two_err_pass_cnt", pass_cnt, 3);
    check("two_err_fail_sel", fail_sel, 1);
    check("two_err_fail_a", fail_a, 3);
    check("two_err_fail_b", fail_b, 5);
    check("two_err_fail_s", fail_s, 14);
`endif

    // Zero-length run
    start = 1'b1; vec_total = '0;
    @(negedge clk);
    start = 1'b0;
    check("zero_run_done", done, 1);
    check("zero_run_pass", pass, 1);
    check("zero_run_counts", {pass_cnt, fail_cnt}, 0);

    // Reset in the middle of a run after 3 transfers
    stim_q.delete();
    for (int i = 0; i < 10; i++) stim_q.push_back(rand_vec(0));
    arm(10);
    drive(3, 0, 1'b0, rc, last);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("rst_midrun", {busy, done, pass, bus.in_ready, pass_cnt, fail_cnt}, 0);
    rst = 1'b0;
    sb_q.delete();
    @(negedge clk);
    check("rst_midrun_idle", {busy, done, bus.in_ready}, 0);

    // Randomized runs with valid gaps; one run takes a start pulse mid-run
    for (int r = 0; r < 5; r++) begin
      int len;
      stim_q.delete();
      len = int'($urandom_range(30, 1));
      for (int i = 0; i < len; i++) stim_q.push_back(rand_vec(bad_pct));
      run_test(30, 1'b0, (r == 2));
    end

`ifdef STOP_ON_FAIL_EN
    // Mismatch on vector 3 halts acceptance
    begin
      int idx = 0, guard = 0;
      stim_q.delete();
      for (int i = 0; i < 10; i++) stim_q.push_back(rand_vec(0));
      stim_q[2] = mk_vec(stim_q[2].a, stim_q[2].b, stim_q[2].sel, 1);
      arm(10);
      while (!done && guard < 100) begin
        if (idx < 10) begin
          bus.in_valid = 1'b1;
          bus.a = N'(stim_q[idx].a); bus.b = N'(stim_q[idx].b);
          bus.sel = 3'(stim_q[idx].sel); bus.s = N'(stim_q[idx].s);
          bus.co = stim_q[idx].co[0];
        end else bus.in_valid = 1'b0;
        if (bus.in_valid && bus.in_ready) begin on_xfer(stim_q[idx]); idx++; end
        @(negedge clk);
        guard++;
      end
      bus.in_valid = 1'b0;
      check("stop_done", done, 1);
      check("stop_total_le4", (int'(pass_cnt) + int'(fail_cnt) <= 4) ? 1 : 0, 1);
      check("stop_fail_ge1", (fail_cnt >= 1) ? 1 : 0, 1);
      check("stop_all_accepted_counted", int'(pass_cnt) + int'(fail_cnt), idx);
      check("stop_fail_sel", fail_sel, stim_q[2].sel);
      check("stop_ready_low", bus.in_ready, 0);
    end
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
